snax_gemm_writeback: RTL and testbench

Downstream stage of the SNAX GEMM accelerator. It accepts one complete C result tile from the GEMM datapath through a valid/ready handshake and registers it. It then writes the tile to TCDM over all accelerator TCDM ports in several beats, tracking each port's grant independently. When the last beat has been accepted it reports completion back to the CSR/control logic.

---
 rtl/snax_gemm_writeback.sv | 150 +++++++++++++++
 tb/tb_snax_gemm_writeback.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/snax_gemm_writeback.sv
// SNAX GEMM C-tile writeback: registers one result tile, then writes it to TCDM over all ports in Beats beats.
// Optional SNAX_GEMM_WB_PERF_EN adds a 32-bit stall-cycle counter output (perf_stall_cnt_o).
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | ready for a new tile (once out of reset)
// WRITE   | issuing beat r_beat; ports with r_granted set stay quiet
module snax_gemm_writeback #(
   parameter int unsigned DataWidth     = 64,
   parameter int unsigned SnaxTcdmPorts = 16,
   parameter int unsigned AddrWidth     = 17,
   parameter int unsigned Beats         = 2,
   localparam int unsigned CWidth       = Beats * SnaxTcdmPorts * DataWidth,
   localparam int unsigned StrbWidth    = DataWidth / 8
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic                                   c_valid_i,
   output logic                                   c_ready_o,
   input  logic [CWidth-1:0]                      c_data_i,
   input  logic [AddrWidth-1:0]                   base_addr_i,
   output logic [SnaxTcdmPorts-1:0]               tcdm_q_valid_o,
   input  logic [SnaxTcdmPorts-1:0]               tcdm_q_ready_i,
   output logic [SnaxTcdmPorts*AddrWidth-1:0]     tcdm_q_addr_o,
   output logic [SnaxTcdmPorts*DataWidth-1:0]     tcdm_q_data_o,
   output logic [SnaxTcdmPorts*StrbWidth-1:0]     tcdm_q_strb_o,
   output logic [SnaxTcdmPorts-1:0]               tcdm_q_write_o,
   output logic                                   busy_o,
   output logic                                   done_o
`ifdef SNAX_GEMM_WB_PERF_EN
   ,
   output logic [31:0]                            perf_stall_cnt_o
`endif
);

   localparam int unsigned P     = SnaxTcdmPorts;
   localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_WRITE = 1'b1;

   logic [0:0]           r_state;
   logic [BeatW-1:0]     r_beat;
   logic [P-1:0]         r_granted;
   logic                 r_done;
   logic                 r_out_of_rst;
   logic [CWidth-1:0]    r_tile;
   logic [AddrWidth-1:0] r_base;

   logic [P-1:0]         w_valid;
   logic [P-1:0]         w_grant_now;
   logic                 w_accept;
   logic                 w_beat_done;
   logic                 w_last_beat;

   assign w_valid     = {P{r_state == S_WRITE}} & ~r_granted;
   assign w_grant_now = w_valid & tcdm_q_ready_i;
   assign w_beat_done = (r_state == S_WRITE) && (&(r_granted | w_grant_now));
   assign w_last_beat = (r_beat == BeatW'(Beats - 1));

   // Ready is held low until the first clock after reset release.
   assign c_ready_o = r_out_of_rst && (r_state == S_IDLE);
   assign w_accept  = c_valid_i && c_ready_o;
   assign busy_o    = (r_state == S_WRITE);
   assign done_o    = r_done;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= S_IDLE;
         r_beat       <= '0;
         r_granted    <= '0;
         r_done       <= 1'b0;
         r_out_of_rst <= 1'b0;
      end else begin
         r_out_of_rst <= 1'b1;
         r_done       <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state   <= S_WRITE;
                  r_beat    <= '0;
                  r_granted <= '0;
               end
            end
            S_WRITE: begin
               if (w_beat_done) begin
                  r_granted <= '0;
                  if (w_last_beat) begin
                     r_state <= S_IDLE;
                     r_beat  <= '0;
                     r_done  <= 1'b1;
                  end else begin
                     r_beat <= r_beat + BeatW'(1);
                  end
               end else begin
                  r_granted <= r_granted | w_grant_now;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_beat    <= '0;
               r_granted <= '0;
            end
         endcase
      end
   end

   // Tile storage has no reset; it is only meaningful after an acceptance.
   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         r_tile <= c_data_i;
         r_base <= base_addr_i;
      end
   end

   always_comb begin
      tcdm_q_valid_o = w_valid;
      tcdm_q_write_o = w_valid;
      tcdm_q_addr_o  = '0;
      tcdm_q_data_o  = '0;
      tcdm_q_strb_o  = '0;
      for (int unsigned p = 0; p < P; p++) begin
         if (w_valid[p]) begin
            tcdm_q_addr_o[p*AddrWidth +: AddrWidth] =
               r_base + AddrWidth'((32'(r_beat) * P + p) * StrbWidth);
            tcdm_q_data_o[p*DataWidth +: DataWidth] =
               r_tile[(32'(r_beat) * P + p) * DataWidth +: DataWidth];
            tcdm_q_strb_o[p*StrbWidth +: StrbWidth] = '1;
         end
      end
   end

`ifdef SNAX_GEMM_WB_PERF_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_stall_cnt <= '0;
      end else if (w_accept) begin
         r_stall_cnt <= '0;
      end else if ((r_state == S_WRITE) && (|(w_valid & ~tcdm_q_ready_i)) &&
                   (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign perf_stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_snax_gemm_writeback.sv
// Directed bench for snax_gemm_writeback: zero-stall, staggered grants, back-to-back, reset mid-write, address wrap.
module tb_snax_gemm_writeback;
   localparam int DW    = 64;
   localparam int P     = 16;
   localparam int AW    = 17;
   localparam int BEATS = 2;
   localparam int CW    = BEATS * P * DW;
   localparam int SW    = DW / 8;

   logic              clk_i = 1'b0;
   logic              rst_ni = 1'b0;
   logic              c_valid_i;
   logic              c_ready_o;
   logic [CW-1:0]     c_data_i;
   logic [AW-1:0]     base_addr_i;
   logic [P-1:0]      tcdm_q_valid_o;
   logic [P-1:0]      tcdm_q_ready_i;
   logic [P*AW-1:0]   tcdm_q_addr_o;
   logic [P*DW-1:0]   tcdm_q_data_o;
   logic [P*SW-1:0]   tcdm_q_strb_o;
   logic [P-1:0]      tcdm_q_write_o;
   logic              busy_o;
   logic              done_o;

   int errors = 0;
   int checks = 0;

   snax_gemm_writeback dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .c_valid_i      (c_valid_i),
      .c_ready_o      (c_ready_o),
      .c_data_i       (c_data_i),
      .base_addr_i    (base_addr_i),
      .tcdm_q_valid_o (tcdm_q_valid_o),
      .tcdm_q_ready_i (tcdm_q_ready_i),
      .tcdm_q_addr_o  (tcdm_q_addr_o),
      .tcdm_q_data_o  (tcdm_q_data_o),
      .tcdm_q_strb_o  (tcdm_q_strb_o),
      .tcdm_q_write_o (tcdm_q_write_o),
      .busy_o         (busy_o),
      .done_o         (done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic load_tile(input logic [AW-1:0] base, input int off);
      for (int k = 0; k < BEATS * P; k++) c_data_i[k*DW +: DW] = DW'(k + off);
      base_addr_i = base;
   endtask

   // Full beat check: every port valid, address base+(beat*P+p)*8, data word off+beat*P+p.
   task automatic check_beat(input string tag, input logic [AW-1:0] base, input int beat, input int off);
      logic [AW-1:0] ea;
      chk({tag, "_valid"}, 64'(tcdm_q_valid_o), 64'hFFFF);
      chk({tag, "_write"}, 64'(tcdm_q_write_o), 64'hFFFF);
      chk({tag, "_strb"}, 64'(&tcdm_q_strb_o), 64'd1);
      chk({tag, "_busy"}, 64'(busy_o), 64'd1);
      for (int p = 0; p < P; p++) begin
         ea = AW'(32'(base) + 32'((beat * P + p) * 8));
         chk($sformatf("%s_addr%0d", tag, p), 64'(tcdm_q_addr_o[p*AW +: AW]), 64'(ea));
         chk($sformatf("%s_data%0d", tag, p), tcdm_q_data_o[p*DW +: DW], 64'(off + beat * P + p));
      end
   endtask

   task automatic check_idle_done(input string tag);
      chk({tag, "_done"}, 64'(done_o), 64'd1);
      chk({tag, "_valid"}, 64'(tcdm_q_valid_o), 64'h0);
      chk({tag, "_busy"}, 64'(busy_o), 64'd0);
      chk({tag, "_ready"}, 64'(c_ready_o), 64'd1);
      chk({tag, "_addr0"}, 64'(tcdm_q_addr_o[AW-1:0]), 64'h0);
      chk({tag, "_strb"}, 64'(|tcdm_q_strb_o), 64'd0);
   endtask

   initial begin
      c_valid_i      = 1'b0;
      tcdm_q_ready_i = '0;
      c_data_i       = '0;
      base_addr_i    = '0;

      #12;
      chk("rst_valid", 64'(tcdm_q_valid_o), 64'h0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_ready", 64'(c_ready_o), 64'd0);
      rst_ni = 1'b1;
      step();
      chk("post_rst_ready", 64'(c_ready_o), 64'd1);

      // Zero-stall tile
      tcdm_q_ready_i = '1;
      load_tile(17'h00100, 0);
      c_valid_i = 1'b1;
      step();
      c_valid_i = 1'b0;
      chk("zs_ready_low", 64'(c_ready_o), 64'd0);
      check_beat("zs_b0", 17'h00100, 0, 0);
      step();
      check_beat("zs_b1", 17'h00100, 1, 0);
      step();
      check_idle_done("zs_end");
      step();
      chk("zs_done_pulse", 64'(done_o), 64'd0);

      // Staggered grant: port 3 withheld for four cycles
      tcdm_q_ready_i = 16'hFFF7;
      load_tile(17'h00300, 50);
      c_valid_i = 1'b1;
      step();
      c_valid_i = 1'b0;
      check_beat("st_b0", 17'h00300, 0, 50);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("st_hold%0d", i), 64'(tcdm_q_valid_o), 64'h0008);
         chk($sformatf("st_done%0d", i), 64'(done_o), 64'd0);
      end
      step();
      chk("st_p3_valid", 64'(tcdm_q_valid_o), 64'h0008);
      chk("st_p3_addr", 64'(tcdm_q_addr_o[3*AW +: AW]), 64'h318);
      chk("st_p3_data", tcdm_q_data_o[3*DW +: DW], 64'd53);
      chk("st_p0_addr_zero", 64'(tcdm_q_addr_o[AW-1:0]), 64'h0);
      tcdm_q_ready_i = '1;
      step();
      check_beat("st_b1", 17'h00300, 1, 50);
      step();
      check_idle_done("st_end");

      // Back-to-back tiles with c_valid_i held high
      step();
      load_tile(17'h00200, 100);
      c_valid_i = 1'b1;
      step();
      chk("bb_ready_n1", 64'(c_ready_o), 64'd0);
      check_beat("bb_a0", 17'h00200, 0, 100);
      load_tile(17'h00400, 200);
      step();
      chk("bb_ready_n2", 64'(c_ready_o), 64'd0);
      check_beat("bb_a1", 17'h00200, 1, 100);
      step();
      check_idle_done("bb_mid");
      step();
      c_valid_i = 1'b0;
      chk("bb_done_low", 64'(done_o), 64'd0);
      check_beat("bb_b0", 17'h00400, 0, 200);
      step();
      check_beat("bb_b1", 17'h00400, 1, 200);
      step();
      check_idle_done("bb_end");

      // Reset asserted during beat 1
      load_tile(17'h00040, 7);
      c_valid_i = 1'b1;
      step();
      c_valid_i = 1'b0;
      step();
      chk("rm_b1_valid", 64'(tcdm_q_valid_o), 64'hFFFF);
      #2 rst_ni = 1'b0;
      #1;
      chk("rm_valid", 64'(tcdm_q_valid_o), 64'h0);
      chk("rm_busy", 64'(busy_o), 64'd0);
      chk("rm_ready", 64'(c_ready_o), 64'd0);
      step();
      chk("rm_done_a", 64'(done_o), 64'd0);
      step();
      chk("rm_done_b", 64'(done_o), 64'd0);
      #3 rst_ni = 1'b1;
      step();
      chk("rm_rel_ready", 64'(c_ready_o), 64'd1);
      chk("rm_rel_done", 64'(done_o), 64'd0);
      chk("rm_rel_busy", 64'(busy_o), 64'd0);

      // Address wrap at the top of the TCDM space
      load_tile(17'h1FFF8, 300);
      c_valid_i = 1'b1;
      step();
      c_valid_i = 1'b0;
      chk("wr_p0_addr", 64'(tcdm_q_addr_o[AW-1:0]), 64'h1FFF8);
      chk("wr_p1_addr", 64'(tcdm_q_addr_o[AW +: AW]), 64'h00000);
      check_beat("wr_b0", 17'h1FFF8, 0, 300);
      step();
      chk("wr_b1_p0_addr", 64'(tcdm_q_addr_o[AW-1:0]), 64'h00078);
      check_beat("wr_b1", 17'h1FFF8, 1, 300);
      step();
      check_idle_done("wr_end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
